// File: rtl/ex_muldiv_iter.sv
// Iterative multiply/divide engine owning HI/LO; STEP bits retired per CALC cycle.
// Optional MULT early exit when MD_EARLY_OUT_EN is defined.
module ex_muldiv_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic             is_sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned N  = WIDTH / STEP;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned W2 = 2 * WIDTH;

    localparam logic [2:0] FnMult = 3'b001;
    localparam logic [2:0] FnDiv  = 3'b010;
    localparam logic [2:0] FnMthi = 3'b011;
    localparam logic [2:0] FnMtlo = 3'b100;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              div_q, div_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dz_q, dz_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [W2-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;
    logic              dz_out_q, dz_out_d;

    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  abs_a, abs_b;
    logic [WIDTH-1:0]  rem_t, quo_t;
    logic [WIDTH:0]    sh;
    logic [W2-1:0]     res;

    assign a_neg = is_sign & a[WIDTH-1];
    assign b_neg = is_sign & b[WIDTH-1];
    assign abs_a = a_neg ? ('0 - a) : a;
    assign abs_b = b_neg ? ('0 - b) : b;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_out_d  = 1'b0;
        rem_t     = acc_q[W2-1:WIDTH];
        quo_t     = acc_q[WIDTH-1:0];
        sh        = '0;
        res       = '0;

        unique case (state_q)
            StIdle: begin
                if (start && !cancel) begin
                    case (func)
                        FnMult, FnDiv: begin
                            state_d   = StCalc;
                            cnt_d     = '0;
                            div_d     = (func == FnDiv);
                            neg_d     = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            dz_d      = (func == FnDiv) && (b == '0);
                            opb_d     = abs_b;
                            if (func == FnDiv) begin
                                acc_d   = {{WIDTH{1'b0}}, abs_a};
                                mcand_d = '0;
                            end else begin
                                acc_d   = '0;
                                mcand_d = {{WIDTH{1'b0}}, abs_a};
                            end
                        end
                        FnMthi:  hi_d = a;
                        FnMtlo:  lo_d = a;
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    if (div_q) begin
                        // Restoring division on {remainder, dividend/quotient}
                        for (int i = 0; i < STEP; i++) begin
                            sh    = {rem_t, quo_t[WIDTH-1]};
                            quo_t = {quo_t[WIDTH-2:0], 1'b0};
                            if (sh >= {1'b0, opb_q}) begin
                                sh       = sh - {1'b0, opb_q};
                                quo_t[0] = 1'b1;
                            end
                            rem_t = sh[WIDTH-1:0];
                        end
                        acc_d = {rem_t, quo_t};
                    end else begin
                        for (int i = 0; i < STEP; i++) begin
                            if (opb_q[i]) acc_d = acc_d + (mcand_q << i);
                        end
                        mcand_d = mcand_q << STEP;
                        opb_d   = opb_q >> STEP;
                    end
                    cnt_d = cnt_q + CW'(1);
`ifdef MD_EARLY_OUT_EN
                    if ((cnt_q == CW'(N - 1)) || (!div_q && (opb_d == '0))) state_d = StFix;
`else
                    if (cnt_q == CW'(N - 1)) state_d = StFix;
`endif
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!cancel) begin
                    done_d   = 1'b1;
                    dz_out_d = dz_q;
                    if (div_q) begin
                        lo_d = dz_q ? '1 : (neg_q ? ('0 - quo_t) : quo_t);
                        hi_d = neg_rem_q ? ('0 - rem_t) : rem_t;
                    end else begin
                        res  = neg_q ? ('0 - acc_q) : acc_q;
                        hi_d = res[W2-1:WIDTH];
                        lo_d = res[WIDTH-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_out_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_out_q  <= dz_out_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign dz   = dz_out_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Bench for ex_muldiv_iter: directed boundary cases plus random ops checked against
// an arithmetic reference model.
module tb_ex_muldiv_iter;
    localparam int N = 32;
    localparam logic [2:0] FMULT = 3'b001;
    localparam logic [2:0] FDIV  = 3'b010;
    localparam logic [2:0] FMTHI = 3'b011;
    localparam logic [2:0] FMTLO = 3'b100;

    logic        clk = 1'b0;
    logic        rst, start, is_sign, cancel;
    logic [2:0]  func;
    logic [31:0] a, b;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    ex_muldiv_iter #(.WIDTH(32), .STEP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .is_sign(is_sign),
        .a(a), .b(b), .cancel(cancel), .busy(busy), .done(done), .dz(dz),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {dz, hi, lo} from plain 64-bit arithmetic
    function automatic logic [64:0] ref_md(input logic [2:0] f, input logic s,
                                           input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = s ? longint'($signed(av)) : longint'({32'b0, av});
        sb = s ? longint'($signed(bv)) : longint'({32'b0, bv});
        if (f == FMULT) begin
            p = sa * sb;
            return {1'b0, p};
        end
        if (bv == 32'd0) return {1'b1, av, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    function automatic int exp_lat(input logic [2:0] f);
`ifdef MD_EARLY_OUT_EN
        return (f == FMULT) ? -1 : N + 1;
`else
        return (f == FMULT) ? N + 1 : N + 1;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic s, input logic [31:0] av,
                         input logic [31:0] bv);
        start = 1'b1; func = f; is_sign = s; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; func = 3'b000;
    endtask

    task automatic wait_done(input string tag, input logic [2:0] f, input logic [64:0] r,
                             input int lat);
        int cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        if (lat >= 0) chk({tag, "_lat"}, 64'(cyc), 64'(lat));
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hilo"}, {hi, lo}, r[63:0]);
        if (f == FDIV) chk({tag, "_dz"}, 64'(dz), 64'(r[64]));
        m_hi = r[63:32];
        m_lo = r[31:0];
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run_md(input string tag, input logic [2:0] f, input logic s,
                          input logic [31:0] av, input logic [31:0] bv);
        logic [64:0] r;
        r = ref_md(f, s, av, bv);
        issue(f, s, av, bv);
        wait_done(tag, f, r, exp_lat(f));
    endtask

    task automatic run_mt(input string tag, input logic [2:0] f, input logic [31:0] av);
        issue(f, 1'b0, av, 32'd0);
        if (f == FMTHI) m_hi = av;
        else m_lo = av;
        chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [64:0] r;
        int          seen;
        int          cyc;
        logic [2:0]  f;

        rst = 1'b0; start = 1'b0; cancel = 1'b0; func = 3'b000; is_sign = 1'b0;
        a = '0; b = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(dz), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_md("mul_s", FMULT, 1'b1, 32'hFFFF_FFFD, 32'd5);
        chk("mul_s_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_md("div_u", FDIV, 1'b0, 32'd100, 32'd7);
        chk("div_u_const", {hi, lo}, 64'h0000_0002_0000_000E);
        run_md("div_s", FDIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div_s_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_md("div_z", FDIV, 1'b1, 32'h0000_1234, 32'd0);
        chk("div_z_const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        run_md("div_min", FDIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_min_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_md("mul_u_max", FMULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        run_mt("mthi", FMTHI, 32'hA5A5_A5A5);

        // MTLO while busy must be dropped
        r = ref_md(FMULT, 1'b0, 32'd6, 32'd7);
        issue(FMULT, 1'b0, 32'd6, 32'd7);
        repeat (3) @(negedge clk);
        issue(FMTLO, 1'b0, 32'hDEAD_BEEF, 32'd0);
        wait_done("mtlo_busy", FMULT, r, -1);

        // Cancel on CALC cycle 10
        issue(FMULT, 1'b1, 32'h1234_5678, 32'hFEDC_BA98);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        chk("cancel_nodone", 64'(seen), 64'd0);
        chk("cancel_hilo", {hi, lo}, {m_hi, m_lo});

        cancel = 1'b1;
        issue(FMULT, 1'b0, 32'd3, 32'd4);
        chk("stcan_busy", 64'(busy), 64'd0);
        issue(FMTHI, 1'b0, 32'h0BAD_0BAD, 32'd0);
        cancel = 1'b0;
        chk("stcan_mthi", {hi, lo}, {m_hi, m_lo});

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    f = FMULT;
                2, 3:    f = FDIV;
                4:       f = $urandom_range(0, 1) ? FMTHI : FMTLO;
                default: f = 3'($urandom_range(5, 8) & 7);
            endcase
            if (f == FMULT || f == FDIV) begin
                run_md($sformatf("rnd%0d", i), f, 1'($urandom_range(0, 1)), pick(), pick());
            end else if (f == FMTHI || f == FMTLO) begin
                run_mt($sformatf("rnd%0d", i), f, pick());
            end else begin
                issue(f, 1'b0, pick(), pick());
                chk($sformatf("rnd%0d_ill_busy", i), 64'(busy), 64'd0);
                chk($sformatf("rnd%0d_ill_hilo", i), {hi, lo}, {m_hi, m_lo});
            end
        end

`ifdef MD_EARLY_OUT_EN
        run_md("early_7x3", FMULT, 1'b0, 32'd7, 32'd3);
        chk("early_const", {hi, lo}, 64'h15);
`endif

        // Asynchronous reset on CALC cycle 5
        run_mt("pre_rst_hi", FMTHI, 32'h1111_1111);
        run_mt("pre_rst_lo", FMTLO, 32'h2222_2222);
        issue(FMULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_dz", 64'(dz), 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cyc = 0;
        run_md("post_rst", FDIV, 1'b1, 32'hFFFF_FF9C, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
